// File: rtl/unidade_controle_multiciclo_pkg.sv
// Shared encodings for the multi-cycle main control FSM.
// Opcodes, funct3 codes, ALUop codes, mux selects and state encoding.
package pacote_controle;

  typedef logic [1:0] aluop_t;
  typedef logic [1:0] sel_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_R      = 7'b0110011;

  localparam logic [2:0] F3_LH   = 3'b001;
  localparam logic [2:0] F3_SH   = 3'b001;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_ANDI = 3'b111;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_SLL  = 3'b001;

  localparam aluop_t ALUOP_MEM  = 2'b00;
  localparam aluop_t ALUOP_BNE  = 2'b01;
  localparam aluop_t ALUOP_R    = 2'b10;
  localparam aluop_t ALUOP_ANDI = 2'b11;

  localparam sel_t SEL_A_PC  = 2'b00;
  localparam sel_t SEL_A_OLD = 2'b01;
  localparam sel_t SEL_A_RS1 = 2'b10;
  localparam sel_t SEL_B_RS2 = 2'b00;
  localparam sel_t SEL_B_4   = 2'b01;
  localparam sel_t SEL_B_IMM = 2'b10;

  typedef enum logic [3:0] {
    INICIO     = 4'd0,
    BUSCA      = 4'd1,
    DECODIFICA = 4'd2,
    CALC_END   = 4'd3,
    LE_MEM     = 4'd4,
    WB_MEM     = 4'd5,
    GRAVA_MEM  = 4'd6,
    EXEC_R     = 4'd7,
    EXEC_I     = 4'd8,
    WB_ALU     = 4'd9,
    DESVIO     = 4'd10,
    ERRO       = 4'd11
  } estado_t;

  function automatic logic r_valido(input logic [2:0] f3);
    return (f3 == F3_ADD) || (f3 == F3_OR) || (f3 == F3_SLL);
  endfunction

endpackage

// File: rtl/unidade_controle_multiciclo_if.sv
// Control bundle between the main FSM (master) and the datapath (slave).
// IR fields and memory ack in; mux selects, enables and ALUop out.
interface unidade_controle_multiciclo_if;
  import pacote_controle::*;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       mem_pronto;
  aluop_t     ALUop;
  sel_t       sel_ula_a;
  sel_t       sel_ula_b;
  logic       le_mem;
  logic       escreve_mem;
  logic       iord;
  logic       escreve_ir;
  logic       escreve_pc;
  logic       escreve_pc_cond;
  logic       escreve_reg;
  logic       mem_para_reg;
  logic       instr_invalida;

  modport master (
    input  opcode, funct3, mem_pronto,
    output ALUop, sel_ula_a, sel_ula_b,
    output le_mem, escreve_mem, iord,
    output escreve_ir, escreve_pc, escreve_pc_cond,
    output escreve_reg, mem_para_reg, instr_invalida
  );

  modport slave (
    output opcode, funct3, mem_pronto,
    input  ALUop, sel_ula_a, sel_ula_b,
    input  le_mem, escreve_mem, iord,
    input  escreve_ir, escreve_pc, escreve_pc_cond,
    input  escreve_reg, mem_para_reg, instr_invalida
  );
endinterface

// File: rtl/unidade_controle_multiciclo.sv
// Multi-cycle main control FSM: fetch, decode, execute, memory, writeback.
// Moore outputs except escreve_ir/escreve_pc, gated by mem_pronto in BUSCA.
module unidade_controle_multiciclo
  import pacote_controle::*;
(
  input logic                          clk,
  input logic                          reset,
  unidade_controle_multiciclo_if.master bus
);

  estado_t r_estado;
  estado_t w_prox;

  logic w_lh, w_sh, w_bne, w_andi, w_rtype;

  assign w_lh    = (bus.opcode == OP_LOAD)   && (bus.funct3 == F3_LH);
  assign w_sh    = (bus.opcode == OP_STORE)  && (bus.funct3 == F3_SH);
  assign w_bne   = (bus.opcode == OP_BRANCH) && (bus.funct3 == F3_BNE);
  assign w_andi  = (bus.opcode == OP_IMM)    && (bus.funct3 == F3_ANDI);
  assign w_rtype = (bus.opcode == OP_R)      && r_valido(bus.funct3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_estado <= INICIO;
    else       r_estado <= w_prox;
  end

  always_comb begin
    w_prox = r_estado;
    unique case (r_estado)
      INICIO:     w_prox = BUSCA;
      BUSCA:      if (bus.mem_pronto) w_prox = DECODIFICA;
      DECODIFICA: begin
        unique case (1'b1)
          w_lh, w_sh: w_prox = CALC_END;
          w_rtype:    w_prox = EXEC_R;
          w_andi:     w_prox = EXEC_I;
          w_bne:      w_prox = DESVIO;
          default:    w_prox = ERRO;
        endcase
      end
      CALC_END:   w_prox = w_lh ? LE_MEM : GRAVA_MEM;
      LE_MEM:     if (bus.mem_pronto) w_prox = WB_MEM;
      WB_MEM:     w_prox = BUSCA;
      GRAVA_MEM:  if (bus.mem_pronto) w_prox = BUSCA;
      EXEC_R:     w_prox = WB_ALU;
      EXEC_I:     w_prox = WB_ALU;
      WB_ALU:     w_prox = BUSCA;
      DESVIO:     w_prox = BUSCA;
      ERRO:       w_prox = ERRO;
      default:    w_prox = INICIO;
    endcase
  end

  always_comb begin
    bus.ALUop           = ALUOP_MEM;
    bus.sel_ula_a       = SEL_A_PC;
    bus.sel_ula_b       = SEL_B_RS2;
    bus.le_mem          = 1'b0;
    bus.escreve_mem     = 1'b0;
    bus.iord            = 1'b0;
    bus.escreve_ir      = 1'b0;
    bus.escreve_pc      = 1'b0;
    bus.escreve_pc_cond = 1'b0;
    bus.escreve_reg     = 1'b0;
    bus.mem_para_reg    = 1'b0;
    bus.instr_invalida  = 1'b0;
    unique case (r_estado)
      BUSCA: begin
        bus.le_mem     = 1'b1;
        bus.sel_ula_b  = SEL_B_4;
        bus.escreve_ir = bus.mem_pronto;
        bus.escreve_pc = bus.mem_pronto;
      end
      DECODIFICA: begin
        bus.sel_ula_a = SEL_A_OLD;
        bus.sel_ula_b = SEL_B_IMM;
      end
      CALC_END: begin
        bus.sel_ula_a = SEL_A_RS1;
        bus.sel_ula_b = SEL_B_IMM;
      end
      LE_MEM: begin
        bus.le_mem = 1'b1;
        bus.iord   = 1'b1;
      end
      WB_MEM: begin
        bus.escreve_reg  = 1'b1;
        bus.mem_para_reg = 1'b1;
      end
      GRAVA_MEM: begin
        bus.escreve_mem = 1'b1;
        bus.iord        = 1'b1;
      end
      EXEC_R: begin
        bus.ALUop     = ALUOP_R;
        bus.sel_ula_a = SEL_A_RS1;
      end
      EXEC_I: begin
        bus.ALUop     = ALUOP_ANDI;
        bus.sel_ula_a = SEL_A_RS1;
        bus.sel_ula_b = SEL_B_IMM;
      end
      WB_ALU: bus.escreve_reg = 1'b1;
      DESVIO: begin
        bus.ALUop           = ALUOP_BNE;
        bus.sel_ula_a       = SEL_A_RS1;
        bus.escreve_pc_cond = 1'b1;
      end
      ERRO:    bus.instr_invalida = 1'b1;
      default: ;
    endcase
  end

endmodule
